// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the RV32M multiply/divide unit
package muldiv_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - operand regs, one-bit shift-add/subtract step, sign fix and result reg
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            fix,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            is_special,
  output logic [XLEN-1:0] result
);

  md_op_e            op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            op_in;
  logic              sa, sb, div_zero, overflow, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign op_in = md_op_e'(func3);

  always_comb begin
    sa = op_a[XLEN-1] && (op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sb = op_b[XLEN-1] && (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    mag_a = sa ? (~op_a + 1'b1) : op_a;
    mag_b = sb ? (~op_b + 1'b1) : op_b;
    // Remainder follows the dividend; quotient and product follow sign_a ^ sign_b.
    neg_in = (op_in == MD_REM) ? sa : (sa ^ sb);

    div_zero = op_is_div(op_in) && (op_b == '0);
    overflow = (op_in inside {MD_DIV, MD_REM}) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    is_special = div_zero || overflow;
    if (div_zero)
      special_res = func3[1] ? op_a : '1;
    else
      special_res = (op_in == MD_REM) ? '0 : op_a;
  end

  always_comb begin
    // Multiply: multiplier sits in acc low half and is consumed LSB first.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}.
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (div_trial[XLEN])
      div_next = {acc_q[2*XLEN-2:0], 1'b0};
    else
      div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (load) begin
      if (is_special) begin
        result_d = special_res;
      end else begin
        op_d  = op_in;
        neg_d = neg_in;
        b_d   = op_is_div(op_in) ? mag_b : mag_a;
        acc_d = {{XLEN{1'b0}}, op_is_div(op_in) ? mag_a : mag_b};
      end
    end else if (step) begin
      acc_d = op_is_div(op_q) ? div_next : mul_next;
    end else if (fix) begin
      case (op_q)
        MD_MUL:                      result_d = prod_fix[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:             result_d = quo_fix;
        default:                     result_d = rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MD_MUL;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit: FSM, iteration counter, handshake
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, is_special;

  assign ready  = (state_q == MD_IDLE) || (state_q == MD_DONE);
  assign busy   = (state_q == MD_CALC) || (state_q == MD_FIX);
  assign done   = (state_q == MD_DONE);
  assign accept = start && ready && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          state_d = MD_IDLE;
          if (start) begin
            if (is_special) begin
              state_d = MD_DONE;
            end else begin
              state_d = MD_CALC;
              cnt_d   = CNT_W'(XLEN);
            end
          end
        end
        MD_CALC: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = MD_FIX;
        end
        MD_FIX:  state_d = MD_DONE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A flush landing in FIX must not overwrite the previously delivered result.
  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .step       ((state_q == MD_CALC) && !flush),
    .fix        ((state_q == MD_FIX) && !flush),
    .func3      (func3),
    .op_a       (op_a),
    .op_b       (op_b),
    .is_special (is_special),
    .result     (result)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, start, flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a, op_b;
  logic            ready, busy, done;
  logic [XLEN-1:0] result;

  int              n_checks = 0;
  int              n_fail = 0;
  int              lat, nbusy, ndone;
  logic [XLEN-1:0] res;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; start is sampled at the next rising edge (cycle 0).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int poke);
    int cyc;
    bit got;
    start = 1'b1; func3 = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; func3 = ~f; op_a = 32'hDEADBEEF; op_b = 32'h12345678;
    lat = 0; nbusy = 0; got = 1'b0; cyc = 1; res = 'x;
    while (!got && cyc <= 80) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; lat = cyc; res = result;
      end else begin
        if (busy) nbusy++;
        start = (cyc == poke);
        if (cyc == poke) begin func3 = 3'b000; op_a = 32'h0F; op_b = 32'h0F; end
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int poke);
    run_op(f, a, b, poke);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, lat, exp_lat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready", ready, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);

    do_op("MUL 7x-3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
    check("MUL busy cycles", nbusy, 33);
    @(negedge clk);
    check("done single pulse", done, 0);
    check("ready after done", ready, 1);
    check("result held", result, 32'hFFFFFFEB);

    // Back-to-back chain: each start lands in the previous op's DONE cycle.
    do_op("MULH", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
    do_op("MULHU", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
    do_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
    do_op("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 0);
    do_op("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 0);
    do_op("DIVU 7/2", 3'b101, 32'd7, 32'd2, 32'd3, 34, 0);
    do_op("REMU 7/2", 3'b111, 32'd7, 32'd2, 32'd1, 34, 0);
    do_op("MUL low", 3'b000, 32'h12345678, 32'h00010000, 32'h56780000, 34, 0);
    do_op("REM 7/-2", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 34, 0);

    do_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    do_op("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    do_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);
    do_op("DIV x/0", 3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1, 0);
    do_op("REMU 9/0", 3'b111, 32'd9, 32'd0, 32'd9, 1, 0);

    do_op("start while busy", 3'b101, 32'd100, 32'd7, 32'd14, 34, 3);
    check("busy poke busy cycles", nbusy, 33);

    // Flush at cycle 10 of a DIV.
    @(negedge clk);
    start = 1'b1; func3 = 3'b100; op_a = 32'd100; op_b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush ready", ready, 1);
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    check("flush result kept", result, 32'd14);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("flush no done", ndone, 0);
    do_op("MUL 3x4 after flush", 3'b000, 32'd3, 32'd4, 32'h0000000C, 34, 0);

    // Flush and start in the same cycle: start is dropped.
    @(negedge clk);
    flush = 1'b1; start = 1'b1; func3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1 flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush+start busy", busy, 0);
    check("flush+start ready", ready, 1);
    check("flush+start done", done, 0);

    // Reset mid-CALC.
    @(negedge clk);
    start = 1'b1; func3 = 3'b000; op_a = 32'd3; op_b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    check("busy before rst", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst ready", ready, 1);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
